// File: rtl/mult_pkg.sv
// Shared types, default sizes and a two's complement helper for the multiply/divide units.
package mult_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 6;
  // Widest value the helper handles: a full 2*WIDTH product at the default width.
  localparam int unsigned MAX_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Conditional two's complement negate. Callers zero-extend into MAX_W and truncate back.
  function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] x, input logic en);
    return en ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiplier.
interface mult_if #(
  parameter int unsigned WIDTH = mult_pkg::WIDTH_DEF
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b, flush, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, flush, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_core.sv
// Shift-add datapath: operand magnitudes, 2*WIDTH accumulator and one iteration per step.
module mult_core
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               neg,
  output logic [2*WIDTH-1:0] prod_nxt_c
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  // One iteration: add into the upper half, then shift {carry, acc} right by one.
  always_comb begin
    addend     = mplier[0] ? mcand : '0;
    sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_nxt_c = {sum, acc[WIDTH-1:1]};
  end

  // Magnitudes are unsigned, so the most-negative operand still fits exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= WIDTH'(neg_if(MAX_W'(a), is_signed & a[WIDTH-1]));
      mplier <= WIDTH'(neg_if(MAX_W'(b), is_signed & b[WIDTH-1]));
      acc    <= '0;
      neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc    <= prod_nxt_c;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// MULT/MULTU unit for EX: sequencing FSM, iteration counter, HI/LO and MTHI/MTLO/flush arbitration.
module mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic    clk,
  input logic    rst_n,
  mult_if.slave  bus
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_nxt, lo_nxt;
  logic               busy_q, done_q;
  logic               load_c, step_c, neg;
  logic [2*WIDTH-1:0] prod_nxt_c;
  logic [2*WIDTH-1:0] result_c;

  mult_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .step       (step_c),
    .is_signed  (bus.is_signed),
    .a          (bus.a),
    .b          (bus.b),
    .neg        (neg),
    .prod_nxt_c (prod_nxt_c)
  );

  // Sign fix-up of the final iteration, written to HI/LO on the completion edge.
  assign result_c = (2*WIDTH)'(neg_if(MAX_W'(prod_nxt_c), neg));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    load_c    = 1'b0;
    step_c    = 1'b0;
    case (state)
      ST_BUSY: begin
        if (bus.flush) begin
          state_nxt = ST_IDLE;
        end else begin
          step_c  = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            {hi_nxt, lo_nxt} = result_c;
            state_nxt        = ST_DONE;
          end
        end
      end
      default: begin
        if (bus.mthi) hi_nxt = bus.wdata;
        if (bus.mtlo) lo_nxt = bus.wdata;
        // A flush in the issue slot kills the same-cycle start.
        if (bus.start && !bus.flush) begin
          load_c    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_BUSY;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      busy_q <= (state_nxt == ST_BUSY);
      done_q <= (state_nxt == ST_DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboarded bench for mult_unit: directed corner cases plus randomized MULT/MULTU.
module tb_mult_unit;

  localparam int unsigned W = 32;
  localparam int LAT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference product from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pending result", cyc);
      end else begin
        e = sbq.pop_front();
        chk("result", {bus.hi, bus.lo}, e.prod);
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y, input bit push);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.is_signed = s; bus.a = x; bus.b = y;
    if (push) sbq.push_back('{prod: model(s, x, y), cyc: cyc + 1 + LAT});
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL done_timeout: got no done within 100 cycles, want done");
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] d);
    @(posedge clk); #1;
    bus.mthi = to_hi; bus.mtlo = !to_hi; bus.wdata = d;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
  endtask

  initial begin
    logic [31:0] x, y;
    logic s;
    bus.start = 0; bus.is_signed = 0; bus.a = '0; bus.b = '0;
    bus.flush = 0; bus.mthi = 0; bus.mtlo = 0; bus.wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic MULTU, busy width and single-cycle done.
    issue(0, 32'd3, 32'd5, 1);
    chk("model_3x5", model(0, 32'd3, 32'd5), 64'h0000_0000_0000_000F);
    wait_done(nb);
    chk("busy_cycles", 64'(nb), 64'd32);
    @(negedge clk);
    chk("done_pulse", 64'(bus.done), 64'd0);

    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done(nb);
    chk("hi_ffxff", 64'(bus.hi), 64'hFFFF_FFFE);
    chk("lo_ffxff", 64'(bus.lo), 64'h0000_0001);

    issue(1, 32'hFFFF_FFF9, 32'd3, 1);
    wait_done(nb);
    chk("mult_m7x3", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done(nb);
    chk("mult_minxm1", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    // Start while busy is ignored; the monitor catches any extra done.
    issue(0, 32'd7, 32'd9, 1);
    repeat (4) @(posedge clk);
    issue(0, 32'd2, 32'd2, 0);
    wait_done(nb);
    repeat (40) @(negedge clk);
    chk("ignored_start_hi", {bus.hi, bus.lo}, 64'd63);

    // Flush mid-operation leaves HI/LO alone and never completes.
    mt(1, 32'h1234);
    mt(0, 32'h5678);
    issue(0, 32'd3, 32'd3, 0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

    // Async reset mid-operation.
    issue(0, 32'd5, 32'd5, 0);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // MTHI in idle, MTLO while busy is dropped.
    mt(1, 32'hAAAA_0000);
    @(negedge clk);
    chk("mthi_idle", 64'(bus.hi), 64'hAAAA_0000);
    issue(0, 32'd3, 32'd5, 1);
    repeat (3) @(posedge clk);
    #1 bus.mtlo = 1'b1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1 bus.mtlo = 1'b0;
    @(negedge clk);
    chk("mtlo_busy", {bus.hi, bus.lo}, 64'hAAAA_0000_0000_0000);
    wait_done(nb);

    // Back-to-back start in the DONE cycle, then MTHI together with start.
    x = $urandom; y = $urandom;
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.a = x; bus.b = y;
    sbq.push_back('{prod: model(1, x, y), cyc: cyc + 1 + LAT});
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(nb);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd6; bus.b = 32'd7;
    bus.mthi = 1'b1; bus.wdata = 32'h55;
    sbq.push_back('{prod: 64'd42, cyc: cyc + 1 + LAT});
    @(posedge clk); #1 bus.start = 1'b0; bus.mthi = 1'b0;
    @(negedge clk);
    chk("mthi_with_start", 64'(bus.hi), 64'h55);
    wait_done(nb);

    // Randomized operands with the occasional corner value.
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'h8000_0000;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'd0;
        default: ;
      endcase
      issue(s, x, y, 1);
      wait_done(nb);
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
